mcpu_vram_arbiter: RTL and testbench

- Shares the single-port 8KB video RAM between two requesters: the CPU data bus (read/write) and the GPU scanout fetch (read only).
- Sits between the CPU bus decoder, the GPU scanout logic and the VRAM array.
- Scanout normally has priority. A starvation counter bounds CPU wait time; when it forces a CPU grant, the displaced scan fetch is dropped and flagged.
- Issues at most one VRAM access per cycle. VRAM read latency is 1 cycle.

---
 rtl/mcpu_vram_pkg.sv | 28 ++
 rtl/mcpu_vram_starve_ctr.sv | 37 +++
 rtl/mcpu_vram_arbiter.sv | 117 +++++++++++
 tb/tb_mcpu_vram_arbiter.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mcpu_vram_pkg.sv
// Shared VRAM arbiter types and VRAM map constants (also used by the GPU side).
package mcpu_vram_pkg;

  localparam int VRAM_SIZE   = 8192;
  localparam int VRAM_ADDR_W = 13;
  localparam int VRAM_DATA_W = 8;

  // Control registers live in the top four bytes of VRAM.
  localparam logic [VRAM_ADDR_W-1:0] REG_CONFIG = 13'h1FFF;  // 8191
  localparam logic [VRAM_ADDR_W-1:0] REG_COLOR0 = 13'h1FFE;  // 8190
  localparam logic [VRAM_ADDR_W-1:0] REG_COLOR1 = 13'h1FFD;  // 8189
  localparam logic [VRAM_ADDR_W-1:0] REG_BORDER = 13'h1FFC;  // 8188

  // Which requester owns the access issued in the previous cycle.
  typedef enum logic [1:0] {
    OWN_NONE   = 2'd0,
    OWN_CPU_RD = 2'd1,
    OWN_CPU_WR = 2'd2,
    OWN_SCAN   = 2'd3
  } owner_e;

  typedef enum logic [1:0] {
    C_IDLE = 2'd0,
    C_PEND = 2'd1,
    C_ACK  = 2'd2
  } cpu_state_e;

endpackage

// File: rtl/mcpu_vram_starve_ctr.sv
// Saturating count of cycles a pending CPU request has lost to scanout.
module mcpu_vram_starve_ctr #(
  parameter int MAX_WAIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc_i,
  input  logic clr_i,
  output logic force_o
);

  localparam logic [3:0] LIMIT = 4'(MAX_WAIT);

  logic [3:0] cnt_q, cnt_d;

  // Clear wins over increment; saturate at the limit so the count never wraps.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q < LIMIT)) begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign force_o = (cnt_q >= LIMIT);

endmodule

// File: rtl/mcpu_vram_arbiter.sv
// Single-port VRAM arbiter: scanout has priority, CPU is force-granted after
// MAX_WAIT lost cycles (dropping the colliding scan fetch).
//
//   state  | meaning
//   C_IDLE | no CPU transaction; a new cpu_req is eligible this cycle
//   C_PEND | CPU request waiting for a grant
//   C_ACK  | access issued last cycle; cpu_ack high, cpu_req ignored
module mcpu_vram_arbiter
  import mcpu_vram_pkg::*;
#(
  parameter int ADDR_W   = VRAM_ADDR_W,
  parameter int DATA_W   = VRAM_DATA_W,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              scan_req,
  input  logic [ADDR_W-1:0] scan_addr,
  output logic              scan_valid,
  output logic [DATA_W-1:0] scan_data,
  output logic              scan_miss,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  cpu_state_e        state_q, state_d;
  owner_e            tag_q, tag_d;
  logic [DATA_W-1:0] cpu_rdata_q, scan_data_q;
  logic              scan_miss_q;

  logic cpu_elig, cpu_force, ctr_force;
  logic grant_scan, grant_cpu, scan_drop;

  assign cpu_elig   = ((state_q == C_IDLE) && cpu_req) || (state_q == C_PEND);
  assign cpu_force  = cpu_elig && ctr_force;
  assign grant_scan = scan_req && !cpu_force;
  assign grant_cpu  = cpu_elig && !grant_scan;
  assign scan_drop  = scan_req && cpu_force;

  mcpu_vram_starve_ctr #(
    .MAX_WAIT(MAX_WAIT)
  ) u_starve_ctr (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc_i  (cpu_elig && !grant_cpu),
    .clr_i  (grant_cpu),
    .force_o(ctr_force)
  );

  // CPU FSM next state and owner tag of this cycle's grant.
  always_comb begin
    state_d = state_q;
    tag_d   = OWN_NONE;
    case (state_q)
      C_IDLE:  if (cpu_req) state_d = grant_cpu ? C_ACK : C_PEND;
      C_PEND:  if (grant_cpu) state_d = C_ACK;
      C_ACK:   state_d = C_IDLE;
      default: state_d = C_IDLE;
    endcase
    if (grant_scan) begin
      tag_d = OWN_SCAN;
    end else if (grant_cpu) begin
      tag_d = cpu_we ? OWN_CPU_WR : OWN_CPU_RD;
    end
  end

  // VRAM port driven from the grant; held inert while in reset.
  always_comb begin
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    if (rst_n) begin
      if (grant_scan) begin
        mem_addr = scan_addr;
      end else if (grant_cpu) begin
        mem_addr = cpu_addr;
        mem_we   = cpu_we;
        if (cpu_we) mem_wdata = cpu_wdata;
      end
    end
  end

  // State, owner tag, and read-data hold registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= C_IDLE;
      tag_q       <= OWN_NONE;
      cpu_rdata_q <= '0;
      scan_data_q <= '0;
      scan_miss_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      tag_q       <= tag_d;
      scan_miss_q <= scan_drop;
      if (tag_q == OWN_CPU_RD) cpu_rdata_q <= mem_rdata;
      if (tag_q == OWN_SCAN)   scan_data_q <= mem_rdata;
    end
  end

  // Read data is forwarded in the response cycle and held afterwards.
  assign cpu_ack    = (state_q == C_ACK);
  assign cpu_rdata  = (tag_q == OWN_CPU_RD) ? mem_rdata : cpu_rdata_q;
  assign scan_valid = (tag_q == OWN_SCAN);
  assign scan_data  = (tag_q == OWN_SCAN) ? mem_rdata : scan_data_q;
  assign scan_miss  = scan_miss_q;
  assign busy       = (state_q != C_IDLE);

endmodule

// File: tb/tb_mcpu_vram_arbiter.sv
// Scoreboard bench for the VRAM arbiter with a behavioural VRAM and
// a cycle-level reference model of the arbitration rules.
module tb_mcpu_vram_arbiter;

  localparam int MAX_WAIT = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [12:0] cpu_addr = '0;
  logic [7:0]  cpu_wdata = '0;
  logic        cpu_ack;
  logic [7:0]  cpu_rdata;
  logic        scan_req = 1'b0;
  logic [12:0] scan_addr = '0;
  logic        scan_valid, scan_miss;
  logic [7:0]  scan_data;
  logic [12:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata = '0;
  logic        busy;

  mcpu_vram_arbiter #(.ADDR_W(13), .DATA_W(8), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .scan_req(scan_req), .scan_addr(scan_addr), .scan_valid(scan_valid),
    .scan_data(scan_data), .scan_miss(scan_miss),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] init_byte(input int i);
    logic [7:0] v;
    v = 8'((i * 37) ^ (i >> 5) ^ 8'h5A);
    if (i == 13'h0123) v = 8'h5A;
    if (i == 13'h0010) v = 8'hAA;
    if (i == 13'h0020) v = 8'hBB;
    return v;
  endfunction

  // Behavioural single-port VRAM with 1-cycle read latency.
  logic [7:0] vram [0:8191];
  initial begin
    for (int i = 0; i < 8192; i++) vram[i] = init_byte(i);
    forever begin
      @(posedge clk);
      mem_rdata <= vram[mem_addr];
      if (mem_we) vram[mem_addr] = mem_wdata;
    end
  end

  int checks = 0;
  int errors = 0;
  int miss_seen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model state.
  typedef struct { int cyc; bit miss; logic [7:0] data; } exp_t;
  exp_t       scan_q[$];
  exp_t       cpu_q[$];
  logic [7:0] shadow [0:8191];
  int         m_cnt = 0;
  bit         m_wait = 0;
  bit         m_ack = 0;
  logic [7:0] last_rd = '0;

  // Monitor: pops expectations whenever the DUT presents a response.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      while (scan_q.size() > 0 && scan_q[0].cyc < cyc) begin
        e = scan_q.pop_front();
        chk("scan_response_missing", 0, 1);
      end
      while (cpu_q.size() > 0 && cpu_q[0].cyc < cyc) begin
        e = cpu_q.pop_front();
        chk("cpu_ack_missing", 0, 1);
      end
      if (scan_miss) miss_seen++;
      if (scan_valid || scan_miss) begin
        if (scan_q.size() == 0 || scan_q[0].cyc != cyc) begin
          chk("scan_unexpected", {scan_valid, scan_miss}, 0);
        end else begin
          e = scan_q.pop_front();
          chk("scan_kind", {scan_valid, scan_miss}, e.miss ? 2'b01 : 2'b10);
          if (!e.miss) chk("scan_data", scan_data, e.data);
        end
      end
      if (cpu_ack) begin
        if (cpu_q.size() == 0 || cpu_q[0].cyc != cyc) begin
          chk("cpu_ack_unexpected", cpu_ack, 0);
        end else begin
          e = cpu_q.pop_front();
          chk("cpu_rdata", cpu_rdata, e.data);
        end
      end
    end
  end

  // One clock of stimulus plus the model's view of that cycle.
  task automatic step(input bit nr, input bit we, input logic [12:0] a, input logic [7:0] d,
                      input bit sc, input logic [12:0] sa);
    bit elig, frc, g_scan, g_cpu;
    exp_t e;
    @(posedge clk); #1;
    if (m_ack || !cpu_req) begin
      cpu_req = nr;
      if (nr) begin cpu_we = we; cpu_addr = a; cpu_wdata = d; end
    end
    scan_req  = sc;
    scan_addr = sa;
    #1;
    elig   = cpu_req && !m_ack;
    frc    = elig && (m_cnt >= MAX_WAIT);
    g_scan = sc && !frc;
    g_cpu  = elig && !g_scan;
    chk("busy", busy, m_wait || m_ack);
    chk("mem_we", mem_we, g_cpu && cpu_we);
    if (g_scan) chk("mem_addr_scan", mem_addr, scan_addr);
    else if (g_cpu) begin
      chk("mem_addr_cpu", mem_addr, cpu_addr);
      if (cpu_we) chk("mem_wdata", mem_wdata, cpu_wdata);
    end
    if (sc) begin
      e.cyc = cyc + 1; e.miss = !g_scan; e.data = shadow[sa];
      scan_q.push_back(e);
    end
    if (g_cpu) begin
      if (cpu_we) shadow[cpu_addr] = cpu_wdata;
      else last_rd = shadow[cpu_addr];
      e.cyc = cyc + 1; e.miss = 0; e.data = last_rd;
      cpu_q.push_back(e);
    end
    m_wait = elig && !g_cpu;
    m_ack  = g_cpu;
    if (g_cpu) m_cnt = 0;
    else if (elig && m_cnt < MAX_WAIT) m_cnt++;
  endtask

  task automatic check_reset_outputs();
    chk("rst_cpu_ack", cpu_ack, 0);
    chk("rst_cpu_rdata", cpu_rdata, 0);
    chk("rst_scan_valid", scan_valid, 0);
    chk("rst_scan_data", scan_data, 0);
    chk("rst_scan_miss", scan_miss, 0);
    chk("rst_busy", busy, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    cpu_req = 1'b0; scan_req = 1'b0;
    scan_q.delete(); cpu_q.delete();
    m_cnt = 0; m_wait = 0; m_ack = 0; last_rd = '0;
    #1 check_reset_outputs();
    repeat (2) @(posedge clk);
    #3 check_reset_outputs();
    rst_n = 1'b1;
  endtask

  function automatic logic [12:0] rnd_addr();
    case ($urandom_range(0, 3))
      0:       return 13'($urandom_range(8184, 8191));
      1:       return 13'($urandom);
      default: return 13'($urandom_range(0, 31));
    endcase
  endfunction

  initial begin
    int m0;
    for (int i = 0; i < 8192; i++) shadow[i] = init_byte(i);
    do_reset();

    // Idle CPU read of 0x0123.
    step(1, 0, 13'h0123, 8'h00, 0, 13'h0);
    step(0, 0, 13'h0, 8'h00, 0, 13'h0);
    step(0, 0, 13'h0, 8'h00, 0, 13'h0);

    // Write to the config register, then read it back.
    step(1, 1, 13'h1FFF, 8'h03, 0, 13'h0);
    step(0, 0, 13'h0, 8'h00, 0, 13'h0);
    step(1, 0, 13'h1FFF, 8'h00, 0, 13'h0);
    step(0, 0, 13'h0, 8'h00, 0, 13'h0);
    step(0, 0, 13'h0, 8'h00, 0, 13'h0);

    // Continuous scanout with a CPU read pending: one forced grant, one miss.
    m0 = miss_seen;
    step(1, 0, 13'h0040, 8'h00, 1, 13'h0100);
    for (int i = 1; i < 8; i++) step(0, 0, 13'h0, 8'h00, 1, 13'(13'h0100 + i));
    step(0, 0, 13'h0, 8'h00, 0, 13'h0);
    chk("starve_miss_count", 32'(miss_seen - m0), 1);

    // Simultaneous scan and CPU read with an empty counter.
    step(1, 0, 13'h0020, 8'h00, 1, 13'h0010);
    step(0, 0, 13'h0, 8'h00, 0, 13'h0);
    step(0, 0, 13'h0, 8'h00, 0, 13'h0);
    step(0, 0, 13'h0, 8'h00, 0, 13'h0);

    // cpu_req held across back-to-back reads.
    for (int i = 0; i < 10; i++) step(1, 0, 13'(i * 3), 8'h00, 0, 13'h0);
    step(0, 0, 13'h0, 8'h00, 0, 13'h0);
    step(0, 0, 13'h0, 8'h00, 0, 13'h0);

    // Reset in the cycle after a CPU read grant, then a normal request.
    step(1, 0, 13'h0055, 8'h00, 0, 13'h0);
    do_reset();
    step(1, 0, 13'h0123, 8'h00, 0, 13'h0);
    step(0, 0, 13'h0, 8'h00, 0, 13'h0);
    step(0, 0, 13'h0, 8'h00, 0, 13'h0);

    // Randomized traffic with varying scanout density.
    for (int i = 0; i < 3000; i++) begin
      int dens;
      dens = (i / 500) % 4;
      step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), rnd_addr(), 8'($urandom),
           $urandom_range(0, 3) < dens, rnd_addr());
    end
    step(0, 0, 13'h0, 8'h00, 0, 13'h0);
    step(0, 0, 13'h0, 8'h00, 0, 13'h0);
    step(0, 0, 13'h0, 8'h00, 0, 13'h0);
    @(negedge clk);
    chk("cpu_queue_drained", cpu_q.size(), 0);
    chk("scan_queue_drained", scan_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
